// File: rtl/square_anim_scheduler_pkg.sv
// Shared types and constants for the square animation scheduler and its sibling blocks.
package square_anim_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_TICK = 2'd2
    } state_t;

    localparam int N_SQ_DEF       = 4;
    localparam int STEP_W_DEF     = 4;
    localparam int GAP_CYCLES_DEF = 4;
    localparam int FCNT_W_DEF     = 16;

    localparam int D_WIDTH  = 640;
    localparam int D_HEIGHT = 480;

    // Counter width able to hold n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/square_anim_scheduler_tick_spacer.sv
// Down-counter that spaces strobes GAP_CYCLES clocks apart: loaded on a strobe,
// it flags expiry on the last waiting cycle so the next strobe lands exactly on time.
module square_anim_scheduler_tick_spacer
    import square_anim_scheduler_pkg::*;
#(
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = cnt_width(GAP_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(GAP_CYCLES - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expire while the count steps from 1 to 0, so the waiting phase lasts GAP_CYCLES-1 cycles.
    assign expire_o = en_i && (cnt_q <= CW'(1));

endmodule

// File: rtl/square_anim_scheduler.sv
// Per-frame tick burst sequencer for bouncing-square sprites, with pause,
// single-step and sticky overrun detection. All outputs come straight from flops.
module square_anim_scheduler
    import square_anim_scheduler_pkg::*;
#(
    parameter int N_SQ       = N_SQ_DEF,
    parameter int STEP_W     = STEP_W_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int FCNT_W     = FCNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_frame,
    input  logic [STEP_W-1:0] i_steps,
    input  logic [N_SQ-1:0]   i_mask,
    input  logic              i_pause,
    input  logic              i_single,
    input  logic              i_clr_ovr,
    output logic              o_tick,
    output logic [N_SQ-1:0]   o_anim,
    output logic              o_busy,
    output logic [FCNT_W-1:0] o_frame_cnt,
    output logic              o_overrun,
    output logic [1:0]        o_state
);

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   left_q, left_d;
    logic [N_SQ-1:0]     mask_q, mask_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                ovr_q, ovr_d;
    logic                tick_q, tick_d;
    logic                busy_q, busy_d;
    logic [N_SQ-1:0]     anim_q, anim_d;
    logic                gap_expire;
    logic                in_burst;

    assign in_burst = (state_q != ST_IDLE);

    square_anim_scheduler_tick_spacer #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_spacer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (state_q == ST_TICK),
        .en_i     (state_q == ST_GAP),
        .expire_o (gap_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            left_q  <= '0;
            mask_q  <= '0;
            fcnt_q  <= '0;
            ovr_q   <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            anim_q  <= '0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            mask_q  <= mask_d;
            fcnt_q  <= fcnt_d;
            ovr_q   <= ovr_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
            anim_q  <= anim_d;
        end
    end

    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        mask_d  = mask_q;
        fcnt_d  = fcnt_q;

        // A frame arriving mid-burst outranks a clear in the same cycle.
        if (i_frame && in_burst) begin
            ovr_d = 1'b1;
        end else if (i_clr_ovr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_frame) begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                    left_d = i_steps;
                    mask_d = i_mask;
                    if (!i_pause && (i_steps != '0)) begin
                        state_d = ST_TICK;
                    end
                end else if (i_single && i_pause) begin
                    left_d  = STEP_W'(1);
                    mask_d  = i_mask;
                    state_d = ST_TICK;
                end
            end
            ST_TICK: begin
                left_d = left_q - STEP_W'(1);
                if (left_q == STEP_W'(1)) begin
                    state_d = ST_IDLE;
                end else if (GAP_CYCLES == 1) begin
                    state_d = ST_TICK;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_expire) begin
                    state_d = ST_TICK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tick_d = (state_d == ST_TICK);
        busy_d = (state_d != ST_IDLE);
        anim_d = busy_d ? mask_d : '0;
    end

    assign o_tick      = tick_q;
    assign o_anim      = anim_q;
    assign o_busy      = busy_q;
    assign o_frame_cnt = fcnt_q;
    assign o_overrun   = ovr_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_square_anim_scheduler.sv
// Bench for square_anim_scheduler: a burst-schedule model checked every cycle,
// plus directed scenarios with hand-computed tick cycles and counter values.
module tb_square_anim_scheduler;

    localparam int N_SQ   = 4;
    localparam int STEP_W = 4;
    localparam int GAP    = 4;
    localparam int FCNT_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_frame;
    logic [STEP_W-1:0] i_steps;
    logic [N_SQ-1:0]   i_mask;
    logic              i_pause;
    logic              i_single;
    logic              i_clr_ovr;
    logic              o_tick;
    logic [N_SQ-1:0]   o_anim;
    logic              o_busy;
    logic [FCNT_W-1:0] o_frame_cnt;
    logic              o_overrun;
    logic [1:0]        o_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit cmp_en  = 1'b0;

    // Model: the active burst occupies cycles [m_from, m_until]; ticks every GAP cycles from m_from.
    int                m_from  = 0;
    int                m_until = -1;
    logic [N_SQ-1:0]   m_mask  = '0;
    logic [FCNT_W-1:0] m_cnt   = '0;
    logic              m_ovr   = 1'b0;

    logic [31:0] tick_log[$];
    logic [31:0] exp_q[$];

    square_anim_scheduler #(
        .N_SQ       (N_SQ),
        .STEP_W     (STEP_W),
        .GAP_CYCLES (GAP),
        .FCNT_W     (FCNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_frame     (i_frame),
        .i_steps     (i_steps),
        .i_mask      (i_mask),
        .i_pause     (i_pause),
        .i_single    (i_single),
        .i_clr_ovr   (i_clr_ovr),
        .o_tick      (o_tick),
        .o_anim      (o_anim),
        .o_busy      (o_busy),
        .o_frame_cnt (o_frame_cnt),
        .o_overrun   (o_overrun),
        .o_state     (o_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin : model
        int  e;
        bit  busy_prev;
        cyc = cyc + 1;
        e   = cyc;
        if (!rst) begin
            m_from  = 0;
            m_until = -1;
            m_mask  = '0;
            m_cnt   = '0;
            m_ovr   = 1'b0;
            cmp_en  = 1'b1;
        end else begin
            busy_prev = ((e - 1) >= m_from) && ((e - 1) <= m_until);
            if (i_frame && busy_prev) m_ovr = 1'b1;
            else if (i_clr_ovr)       m_ovr = 1'b0;
            if (i_frame && !busy_prev) begin
                m_cnt = m_cnt + 1'b1;
                if (!i_pause && (i_steps != 0)) begin
                    m_from  = e;
                    m_until = e + (int'(i_steps) - 1) * GAP;
                    m_mask  = i_mask;
                end
            end else if (!i_frame && i_single && i_pause && !busy_prev) begin
                m_from  = e;
                m_until = e;
                m_mask  = i_mask;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit busy_now;
        bit tick_now;
        if (o_tick === 1'b1) tick_log.push_back(32'(cyc));
        if (cmp_en) begin
            busy_now = (cyc >= m_from) && (cyc <= m_until);
            tick_now = busy_now && (((cyc - m_from) % GAP) == 0);
            check("m_tick",    32'(o_tick),      32'(tick_now));
            check("m_busy",    32'(o_busy),      32'(busy_now));
            check("m_anim",    32'(o_anim),      busy_now ? 32'(m_mask) : 32'd0);
            check("m_fcnt",    32'(o_frame_cnt), 32'(m_cnt));
            check("m_overrun", 32'(o_overrun),   32'(m_ovr));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic [STEP_W-1:0] steps, input logic [N_SQ-1:0] mask, output int fc);
        i_steps = steps;
        i_mask  = mask;
        i_frame = 1'b1;
        fc      = cyc;
        step(1);
        i_frame = 1'b0;
    endtask

    task automatic check_ticks(input string name);
        check({name, "_count"}, 32'(tick_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < tick_log.size() && i < exp_q.size(); i++) begin
            check(name, tick_log[i], exp_q[i]);
        end
    endtask

    initial begin : stim
        int fc;
        int dummy;
        rst = 1'b0; i_frame = 1'b0; i_steps = '0; i_mask = '0;
        i_pause = 1'b0; i_single = 1'b0; i_clr_ovr = 1'b0;
        step(3);
        check("rst_fcnt",  32'(o_frame_cnt), 32'd0);
        check("rst_state", 32'(o_state),     32'd0);
        rst = 1'b1;
        step(5);

        // Three-step burst: ticks at frame+1, +5, +9.
        tick_log.delete();
        frame(4'd3, 4'b0101, fc);
        check("t1_anim", 32'(o_anim), 32'h5);
        step(14);
        exp_q = '{32'(fc + 1), 32'(fc + 5), 32'(fc + 9)};
        check_ticks("t1_ticks");
        check("t1_fcnt", 32'(o_frame_cnt), 32'd1);
        check("t1_busy", 32'(o_busy), 32'd0);

        // Zero steps: counted, no tick.
        tick_log.delete();
        frame(4'd0, 4'b1111, fc);
        step(5);
        exp_q = {};
        check_ticks("t2_ticks");
        check("t2_fcnt", 32'(o_frame_cnt), 32'd2);

        // Overrun during a burst; set beats a simultaneous clear.
        tick_log.delete();
        frame(4'd3, 4'b0101, fc);
        step(3);
        frame(4'd7, 4'b1111, dummy);
        check("t3_ovr_set", 32'(o_overrun), 32'd1);
        i_frame = 1'b1; i_clr_ovr = 1'b1;
        step(1);
        i_frame = 1'b0; i_clr_ovr = 1'b0;
        check("t3_set_wins", 32'(o_overrun), 32'd1);
        step(10);
        exp_q = '{32'(fc + 1), 32'(fc + 5), 32'(fc + 9)};
        check_ticks("t3_ticks");
        check("t3_fcnt", 32'(o_frame_cnt), 32'd3);
        i_clr_ovr = 1'b1;
        step(1);
        i_clr_ovr = 1'b0;
        check("t3_ovr_clr", 32'(o_overrun), 32'd0);

        // Paused frame, then single-step.
        tick_log.delete();
        i_pause = 1'b1;
        frame(4'd3, 4'b0011, fc);
        step(4);
        exp_q = {};
        check_ticks("t4_paused");
        check("t4_fcnt", 32'(o_frame_cnt), 32'd4);
        i_mask = 4'b1000; i_single = 1'b1; fc = cyc;
        step(1);
        i_single = 1'b0;
        check("t4_tick", 32'(o_tick), 32'd1);
        check("t4_anim", 32'(o_anim), 32'h8);
        step(5);
        exp_q = '{32'(fc + 1)};
        check_ticks("t4_single");
        check("t4_fcnt2", 32'(o_frame_cnt), 32'd4);
        i_pause = 1'b0;
        tick_log.delete();
        i_single = 1'b1;
        step(1);
        i_single = 1'b0;
        step(4);
        exp_q = {};
        check_ticks("t4_single_unpaused");

        // Reset in the middle of a five-step burst.
        tick_log.delete();
        frame(4'd5, 4'b0011, fc);
        step(4);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        check("t5_fcnt", 32'(o_frame_cnt), 32'd0);
        check("t5_busy", 32'(o_busy), 32'd0);
        check("t5_anim", 32'(o_anim), 32'd0);
        step(10);
        exp_q = '{32'(fc + 1), 32'(fc + 5)};
        check_ticks("t5_abort");
        tick_log.delete();
        frame(4'd2, 4'b0110, fc);
        step(10);
        exp_q = '{32'(fc + 1), 32'(fc + 5)};
        check_ticks("t5_after");
        check("t5_fcnt2", 32'(o_frame_cnt), 32'd1);

        // Frame and single together: frame wins.
        tick_log.delete();
        i_single = 1'b1;
        frame(4'd1, 4'b1001, fc);
        i_single = 1'b0;
        step(6);
        exp_q = '{32'(fc + 1)};
        check_ticks("t6_ticks");
        check("t6_fcnt", 32'(o_frame_cnt), 32'd2);

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
